// File: rtl/axi_read_arbiter_pkg.sv
// Shared types and constants for the AXI read-channel arbiter.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StResp
  } state_e;

  typedef enum logic {
    OwnInst = 1'b0,
    OwnData = 1'b1
  } owner_e;

  localparam logic [3:0] IdInstDefault = 4'd0;
  localparam logic [3:0] IdDataDefault = 4'd1;

  localparam logic [2:0] SizeByte = 3'd0;
  localparam logic [2:0] SizeHalf = 3'd1;
  localparam logic [2:0] SizeWord = 3'd2;

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read address / read data channel bundle (AR and R only).
interface axi_read_arbiter_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arsize, arvalid, rready,
    input  arready, rid, rdata, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arsize, arvalid, rready,
    output arready, rid, rdata, rlast, rvalid
  );

endinterface

// File: rtl/axi_read_arbiter.sv
// Sequences the shared AXI read channel between instruction fetch and data load.
// One read outstanding; round-robin on ties; flushed fetches are drained silently.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter logic [3:0] ID_INST = IdInstDefault,
  parameter logic [3:0] ID_DATA = IdDataDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_rvalid,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [2:0]  data_size,
  output logic [31:0] data_rdata,
  output logic        data_rvalid,
  input  logic        flush,
  axi_read_arbiter_if.master axi
);

  state_e      state_q;
  owner_e      owner_q;
  owner_e      last_owner_q;
  logic        drop_q;
  logic        arvalid_q;
  logic        rready_q;
  logic [3:0]  arid_q;
  logic [31:0] araddr_q;
  logic [2:0]  arsize_q;

  logic   inst_elig;
  logic   grant_any;
  logic   grant_data;
  owner_e grant_owner;
  logic   r_hs;

  // Two-input round-robin: data wins a tie only if inst was granted last.
  always_comb begin
    inst_elig   = inst_req & ~flush;
    grant_any   = inst_elig | data_req;
    grant_data  = data_req & (~inst_elig | (last_owner_q == OwnInst));
    grant_owner = grant_data ? OwnData : OwnInst;
    r_hs        = rready_q & axi.rvalid;
    inst_rvalid = r_hs & (owner_q == OwnInst) & ~drop_q & ~flush;
    data_rvalid = r_hs & (owner_q == OwnData);
  end

  assign inst_rdata  = axi.rdata;
  assign data_rdata  = axi.rdata;
  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arsize  = arsize_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  // Read sequencer: latch the winner, hold AR until accepted, wait for the single beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnInst;
      last_owner_q <= OwnInst;
      drop_q       <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arsize_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_any) begin
            owner_q      <= grant_owner;
            last_owner_q <= grant_owner;
            arid_q       <= grant_data ? ID_DATA : ID_INST;
            araddr_q     <= grant_data ? data_addr : inst_addr;
            arsize_q     <= grant_data ? data_size : SizeWord;
            arvalid_q    <= 1'b1;
            state_q      <= StAddr;
          end
        end
        StAddr: begin
          if (flush && (owner_q == OwnInst)) drop_q <= 1'b1;
          // AR stays asserted through a flush; the read is drained instead.
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StResp;
          end
        end
        StResp: begin
          if (flush && (owner_q == OwnInst)) drop_q <= 1'b1;
          if (axi.rvalid) begin
            rready_q <= 1'b0;
            drop_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  // Load requester must hold its request until served.
  a_data_req_held: assert property (@(posedge clk) disable iff (reset)
    (data_req && !data_rvalid) |=> data_req);

  // Single-beat responses must carry the issued id.
  a_rid_match: assert property (@(posedge clk) disable iff (reset)
    r_hs |-> ((axi.rid == arid_q) && axi.rlast));

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: random AXI slave timing, a transaction-level
// reference model of grant order, AR/R phases and response delivery.
module tb_axi_read_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst_rdata;
  logic        inst_rvalid;
  logic        data_req = 1'b0;
  logic [31:0] data_addr = '0;
  logic [2:0]  data_size = '0;
  logic [31:0] data_rdata;
  logic        data_rvalid;
  logic        flush = 1'b0;

  axi_read_arbiter_if bus ();

  axi_read_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_rvalid(inst_rvalid),
    .data_req   (data_req),
    .data_addr  (data_addr),
    .data_size  (data_size),
    .data_rdata (data_rdata),
    .data_rvalid(data_rvalid),
    .flush      (flush),
    .axi        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave timing knobs: negative means random 0..3 cycles.
  int          ar_cfg = 0;
  int          r_cfg = 0;
  bit          fixed_rdata = 1'b0;
  logic [31:0] rdata_val = '0;

  function automatic int pick(input int cfg);
    return (cfg < 0) ? int'($urandom_range(3, 0)) : cfg;
  endfunction

  // AXI slave: accepts AR after a delay, returns one beat after another delay.
  int         s_ph = 0;
  int         s_cnt = 0;
  logic [3:0] s_id = '0;

  task automatic send_beat();
    bus.rvalid = 1'b1;
    bus.rid    = s_id;
    bus.rlast  = 1'b1;
    bus.rdata  = fixed_rdata ? rdata_val : $urandom;
  endtask

  initial begin
    bus.arready = 1'b0;
    bus.rvalid  = 1'b0;
    bus.rid     = '0;
    bus.rdata   = '0;
    bus.rlast   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.rdata = $urandom;
      bus.rlast = 1'b0;
      if (reset) begin
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        s_ph        = 0;
        s_cnt       = pick(ar_cfg);
      end else begin
        case (s_ph)
          0: begin
            if (!bus.arvalid) s_cnt = pick(ar_cfg);
            else if (s_cnt == 0) begin
              bus.arready = 1'b1;
              s_id        = bus.arid;
              s_ph        = 1;
            end else s_cnt--;
          end
          1: begin
            bus.arready = 1'b0;
            s_cnt       = pick(r_cfg);
            if (s_cnt == 0) begin
              send_beat();
              s_ph = 3;
            end else s_ph = 2;
          end
          2: begin
            s_cnt--;
            if (s_cnt == 0) begin
              send_beat();
              s_ph = 3;
            end
          end
          default: begin
            bus.rvalid = 1'b0;
            s_cnt      = pick(ar_cfg);
            s_ph       = 0;
          end
        endcase
      end
    end
  end

  // Reference model: owner 1 = data, 0 = inst.
  bit          m_idle = 1'b1;
  bit          m_resp = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_last = 1'b0;
  bit          m_drop = 1'b0;
  bit          chk_ar = 1'b0;
  bit          was_reset = 1'b0;
  bit          hs, ie, de;
  logic [3:0]  e_id = '0;
  logic [31:0] e_addr = '0;
  logic [2:0]  e_size = '0;
  int          n_inst = 0;
  int          n_data = 0;
  logic [31:0] last_inst_rdata = '0;
  logic [3:0]  grant_q[$];

  always @(negedge clk) begin
    check("inst_rdata_pass", inst_rdata, bus.rdata);
    check("data_rdata_pass", data_rdata, bus.rdata);
    if (reset) begin
      check("rst_inst_rvalid", {31'd0, inst_rvalid}, 32'd0);
      check("rst_data_rvalid", {31'd0, data_rvalid}, 32'd0);
      m_idle    = 1'b1;
      m_resp    = 1'b0;
      m_last    = 1'b0;
      m_drop    = 1'b0;
      chk_ar    = 1'b0;
      was_reset = 1'b1;
    end else begin
      if (was_reset) begin
        check("rst_arid", {28'd0, bus.arid}, 32'd0);
        check("rst_araddr", bus.araddr, 32'd0);
        check("rst_arsize", {29'd0, bus.arsize}, 32'd0);
        was_reset = 1'b0;
      end
      if (chk_ar) begin
        check("arid", {28'd0, bus.arid}, {28'd0, e_id});
        check("araddr", bus.araddr, e_addr);
        check("arsize", {29'd0, bus.arsize}, {29'd0, e_size});
        grant_q.push_back(bus.arid);
        chk_ar = 1'b0;
      end
      check("arvalid", {31'd0, bus.arvalid}, {31'd0, !m_idle && !m_resp});
      check("rready", {31'd0, bus.rready}, {31'd0, !m_idle && m_resp});
      if (!m_idle && !m_owner && flush) m_drop = 1'b1;
      hs = !m_idle && m_resp && bus.rvalid;
      check("inst_rvalid", {31'd0, inst_rvalid}, {31'd0, hs && !m_owner && !m_drop});
      check("data_rvalid", {31'd0, data_rvalid}, {31'd0, hs && m_owner});
      if (hs) check("rid", {28'd0, bus.rid}, {28'd0, e_id});
      if (inst_rvalid) begin
        n_inst++;
        last_inst_rdata = inst_rdata;
      end
      if (data_rvalid) n_data++;
      if (m_idle) begin
        ie = inst_req && !flush;
        de = data_req;
        if (ie || de) begin
          m_owner = de && (!ie || !m_last);
          m_last  = m_owner;
          e_id    = m_owner ? 4'd1 : 4'd0;
          e_addr  = m_owner ? data_addr : inst_addr;
          e_size  = m_owner ? data_size : 3'd2;
          m_idle  = 1'b0;
          m_resp  = 1'b0;
          m_drop  = 1'b0;
          chk_ar  = 1'b1;
        end
      end else if (!m_resp) begin
        if (bus.arvalid && bus.arready) m_resp = 1'b1;
      end else if (hs) begin
        m_idle = 1'b1;
      end
    end
  end

  task automatic wait_inst(input int n0);
    int t = 0;
    while (n_inst == n0 && t < 60) begin
      tick();
      t++;
    end
    check("wait_inst_timeout", {31'd0, n_inst != n0}, 32'd1);
  endtask

  task automatic wait_data(input int n0);
    int t = 0;
    while (n_data == n0 && t < 60) begin
      tick();
      t++;
    end
    check("wait_data_timeout", {31'd0, n_data != n0}, 32'd1);
  endtask

  // Wait (at posedge+3) until an interface flag observed high; bounded.
  task automatic wait_rready();
    int t = 0;
    do begin
      tick();
      #2;
      t++;
    end while (!bus.rready && t < 60);
    check("wait_rready_timeout", {31'd0, bus.rready}, 32'd1);
  endtask

  task automatic new_data();
    data_req  = 1'b1;
    data_addr = $urandom;
    data_size = 3'($urandom_range(2, 0));
  endtask

  task automatic new_inst();
    inst_req  = 1'b1;
    inst_addr = $urandom & 32'hFFFF_FFFC;
  endtask

  // Requester driver; rnd=0 keeps both requesters continuously busy with no flushes.
  task automatic run_traffic(input bit rnd, input int ngrants, input int max_cycles);
    int sd = n_data;
    int si = n_inst;
    int g0 = grant_q.size();
    int t = 0;
    bit stop = 1'b0;
    bit flush_prev = 1'b0;
    while (t < max_cycles) begin
      stop = (grant_q.size() - g0) >= ngrants;
      if (n_data != sd) begin
        sd = n_data;
        if (stop || (rnd && $urandom_range(1, 0) == 0)) data_req = 1'b0;
        else new_data();
      end else if (!data_req && !stop && (!rnd || $urandom_range(3, 0) == 0)) new_data();
      if (n_inst != si || flush_prev) begin
        si = n_inst;
        if (stop || (rnd && $urandom_range(1, 0) == 0)) inst_req = 1'b0;
        else new_inst();
      end else if (!inst_req && !stop && (!rnd || $urandom_range(3, 0) == 0)) new_inst();
      flush_prev = flush;
      flush = rnd && !stop && ($urandom_range(9, 0) == 0);
      if (stop && !data_req && !inst_req) break;
      tick();
      t++;
    end
    check("traffic_drain", {31'd0, data_req | inst_req}, 32'd0);
    flush = 1'b0;
    repeat (4) tick();
  endtask

  int n0, g0;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Single fetch with fixed slave timing.
    ar_cfg      = 0;
    r_cfg       = 1;
    fixed_rdata = 1'b1;
    rdata_val   = 32'h3C08_0001;
    inst_addr   = 32'hBFC0_0000;
    inst_req    = 1'b1;
    n0 = n_inst;
    wait_inst(n0);
    inst_req = 1'b0;
    check("s1_rdata", last_inst_rdata, 32'h3C08_0001);
    check("s1_arid", {28'd0, grant_q[grant_q.size()-1]}, 32'd0);
    fixed_rdata = 1'b0;
    repeat (3) tick();

    // Both pending from reset: data first, then strict alternation.
    ar_cfg = -1;
    r_cfg  = -1;
    reset  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    g0 = grant_q.size();
    run_traffic(1'b0, 5, 400);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("s2_grant%0d", i), {28'd0, grant_q[g0+i]}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Flush while AR is stalled: drained, no pulse; refetch returns normally.
    ar_cfg    = 4;
    r_cfg     = 0;
    inst_addr = 32'hBFC0_0100;
    inst_req  = 1'b1;
    for (int t = 0; t < 20 && !bus.arvalid; t++) tick();
    n0 = n_inst;
    flush    = 1'b1;
    inst_req = 1'b0;
    tick();
    flush = 1'b0;
    repeat (12) tick();
    check("s3_no_pulse", n_inst, n0);
    ar_cfg    = 0;
    inst_addr = 32'hBFC0_0380;
    inst_req  = 1'b1;
    wait_inst(n0);
    inst_req = 1'b0;
    check("s3_refetch_id", {28'd0, grant_q[grant_q.size()-1]}, 32'd0);
    repeat (3) tick();

    // Flush coincident with the inst beat.
    r_cfg     = 2;
    inst_addr = 32'hBFC0_0200;
    inst_req  = 1'b1;
    n0 = n_inst;
    for (int t = 0; t < 30; t++) begin
      tick();
      #2;
      if (bus.rvalid) break;
    end
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    inst_req = 1'b0;
    repeat (3) tick();
    check("s4_suppressed", n_inst, n0);

    // Data read in flight during a flush is delivered.
    r_cfg     = 3;
    data_addr = 32'h8000_1000;
    data_size = 3'd2;
    data_req  = 1'b1;
    n0 = n_data;
    wait_rready();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_data(n0);
    data_req = 1'b0;
    check("s4_data_count", n_data, n0 + 1);

    // Byte load at an odd address, delivered once.
    ar_cfg    = -1;
    r_cfg     = -1;
    data_addr = 32'h8000_0003;
    data_size = 3'd0;
    data_req  = 1'b1;
    n0 = n_data;
    wait_data(n0);
    data_req = 1'b0;
    repeat (5) tick();
    check("s5_once", n_data, n0 + 1);
    check("s5_arid", {28'd0, grant_q[grant_q.size()-1]}, 32'd1);

    // Reset in the response phase.
    r_cfg     = 5;
    inst_addr = 32'hBFC0_0400;
    inst_req  = 1'b1;
    wait_rready();
    n0 = n_inst;
    reset    = 1'b1;
    inst_req = 1'b0;
    tick();
    check("s6_arvalid", {31'd0, bus.arvalid}, 32'd0);
    check("s6_rready", {31'd0, bus.rready}, 32'd0);
    tick();
    reset = 1'b0;
    repeat (8) tick();
    check("s6_no_pulse", n_inst, n0);
    r_cfg     = -1;
    inst_addr = 32'hBFC0_0500;
    inst_req  = 1'b1;
    wait_inst(n0);
    inst_req = 1'b0;
    repeat (3) tick();

    // Randomized traffic with flushes.
    run_traffic(1'b1, 300, 8000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
